// File: rtl/jt900h_udma_eng.sv
// jt900h_udma_eng: TLCS-900H micro-DMA, NCH-channel register file plus a one-datum-per-trigger sequencer.
// Define JT900H_UDMA_ROTPRIO_EN for round-robin channel arbitration; otherwise fixed priority, channel 0 first.
module jt900h_udma_eng #(
    parameter  int NCH = 4,
    parameter  int AW  = 24,
    localparam int CW  = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic            rst,
    input  logic            clk,
    input  logic            cen,
    input  logic [31:0]     regin,
    input  logic [CW+3:0]   regsel,
    input  logic [2:0]      regwe,
    input  logic            int_inc,
    input  logic            int_dec,
    output logic [31:0]     regout,
    input  logic [NCH-1:0]  trig,
    output logic [NCH-1:0]  tc_irq,
    output logic            busy,
    output logic            bus_req,
    output logic            bus_we,
    output logic [1:0]      bus_size,
    output logic [AW-1:0]   bus_addr,
    output logic [31:0]     bus_dout,
    input  logic [31:0]     bus_din,
    input  logic            bus_ack
);

    localparam logic [CW:0] NCH_W = (CW+1)'(NCH);

    typedef enum logic [2:0] {IDLE, ARB, RD, WR, UPD} state_t;

    state_t         state;
    logic [31:0]    src  [NCH];
    logic [31:0]    dst  [NCH];
    logic [15:0]    cnt  [NCH];
    logic [7:0]     mode [NCH];
    logic [15:0]    intnest;
    logic [NCH-1:0] pending;
    logic [NCH-1:0] trig_q;
    logic [NCH-1:0] rise;
    logic [CW-1:0]  cur;
    logic [CW-1:0]  last;
    logic [CW-1:0]  arb_ch;
    logic           arb_hit;

    logic [1:0]     bank;
    logic [CW-1:0]  chan;
    logic [1:0]     lane;
    logic           chan_ok;
    logic           wr_ok;
    logic [31:0]    rd_mux;

    logic [4:0]     cmode;
    logic [31:0]    step;
    logic [1:0]     csize;

    assign bank    = regsel[CW+3:CW+2];
    assign chan    = regsel[CW+1:2];
    assign lane    = regsel[1:0];
    assign chan_ok = {1'b0, chan} < NCH_W;
    assign wr_ok   = chan_ok && (regwe != 3'b000);
    assign rise    = trig & ~trig_q;

    assign cmode = mode[cur][4:0];
    assign csize = (cmode[4:3] == 2'd3) ? 2'd2 : cmode[4:3];

    always_comb begin
        case (cmode[4:3])
            2'd0:    step = 32'd1;
            2'd1:    step = 32'd2;
            default: step = 32'd4;
        endcase
    end

    // Lane merge for 32-bit pointer registers: long replaces, word/byte patch one lane from regin's low bits.
    function automatic logic [31:0] merge32(input logic [31:0] old, input logic [31:0] d,
                                            input logic [2:0] we, input logic [1:0] ln);
        logic [31:0] r;
        r = old;
        if (we[2])
            r = d;
        else if (we[1]) begin
            if (ln[1]) r[31:16] = d[15:0];
            else       r[15:0]  = d[15:0];
        end else if (we[0])
            r[{ln, 3'b000} +: 8] = d[7:0];
        return r;
    endfunction

    always_comb begin
        rd_mux = 32'd0;
        if (chan_ok) begin
            case (bank)
                2'd0:    rd_mux = src[chan];
                2'd1:    rd_mux = dst[chan];
                2'd2:    rd_mux = {8'd0, mode[chan], cnt[chan]};
                default: rd_mux = {16'd0, intnest};
            endcase
        end
    end

    always_comb begin
        int idx;
        idx     = 0;
        arb_hit = 1'b0;
        arb_ch  = '0;
`ifdef JT900H_UDMA_ROTPRIO_EN
        // Walk from furthest to nearest so the channel right after the last served one wins.
        for (int k = NCH; k >= 1; k--) begin
            idx = (int'(last) + k) % NCH;
            if (pending[idx]) begin
                arb_hit = 1'b1;
                arb_ch  = CW'(idx);
            end
        end
`else
        for (int k = NCH - 1; k >= 0; k--) begin
            if (pending[k]) begin
                arb_hit = 1'b1;
                arb_ch  = CW'(k);
            end
        end
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            for (int i = 0; i < NCH; i++) begin
                src[i]  <= 32'd0;
                dst[i]  <= 32'd0;
                cnt[i]  <= 16'd0;
                mode[i] <= 8'd0;
            end
            intnest  <= 16'd0;
            pending  <= '0;
            trig_q   <= '0;
            cur      <= '0;
            last     <= CW'(NCH - 1);
            regout   <= 32'd0;
            tc_irq   <= '0;
            busy     <= 1'b0;
            bus_req  <= 1'b0;
            bus_we   <= 1'b0;
            bus_size <= 2'd0;
            bus_addr <= '0;
            bus_dout <= 32'd0;
        end else if (cen) begin
            trig_q <= trig;
            tc_irq <= '0;
            regout <= rd_mux;

            // A new edge on the channel being serviced is absorbed by the current transfer.
            for (int i = 0; i < NCH; i++) begin
                if (rise[i] && !(state != IDLE && cur == CW'(i)))
                    pending[i] <= 1'b1;
            end

            case (state)
                IDLE: begin
                    if (arb_hit) begin
                        cur   <= arb_ch;
                        last  <= arb_ch;
                        busy  <= 1'b1;
                        state <= ARB;
                    end
                end
                ARB: begin
                    bus_req  <= 1'b1;
                    bus_we   <= 1'b0;
                    bus_size <= csize;
                    bus_addr <= src[cur][AW-1:0];
                    state    <= RD;
                end
                RD: begin
                    if (bus_ack) begin
                        bus_we   <= 1'b1;
                        bus_addr <= dst[cur][AW-1:0];
                        bus_dout <= bus_din;
                        state    <= WR;
                    end
                end
                WR: begin
                    if (bus_ack) begin
                        bus_req <= 1'b0;
                        bus_we  <= 1'b0;
                        state   <= UPD;
                    end
                end
                UPD: begin
                    case (cmode[2:0])
                        3'd0:    dst[cur] <= dst[cur] + step;
                        3'd1:    dst[cur] <= dst[cur] - step;
                        3'd2:    src[cur] <= src[cur] + step;
                        3'd3:    src[cur] <= src[cur] - step;
                        default: ;
                    endcase
                    cnt[cur]     <= cnt[cur] - 16'd1;
                    pending[cur] <= 1'b0;
                    if (cnt[cur] == 16'd1)
                        tc_irq[cur] <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase

            // CPU register writes come after the sequencer update so they take precedence.
            if (wr_ok) begin
                case (bank)
                    2'd0: src[chan] <= merge32(src[chan], regin, regwe, lane);
                    2'd1: dst[chan] <= merge32(dst[chan], regin, regwe, lane);
                    2'd2: begin
                        if (regwe[2]) begin
                            mode[chan] <= regin[23:16];
                            cnt[chan]  <= regin[15:0];
                        end else if (lane[1])
                            mode[chan] <= regin[7:0];
                        else if (regwe[1])
                            cnt[chan] <= regin[15:0];
                        else
                            cnt[chan][{lane[0], 3'b000} +: 8] <= regin[7:0];
                    end
                    default: ;
                endcase
            end

            if (wr_ok && bank == 2'd3) begin
                if (regwe[2] || regwe[1])
                    intnest <= regin[15:0];
                else
                    intnest[{lane[0], 3'b000} +: 8] <= regin[7:0];
            end else if (int_inc && !int_dec && intnest != 16'hFFFF)
                intnest <= intnest + 16'd1;
            else if (int_dec && !int_inc && intnest != 16'h0000)
                intnest <= intnest - 16'd1;
        end
    end

endmodule

// File: tb/tb_jt900h_udma_eng.sv
// Directed bench for jt900h_udma_eng (NCH=4, AW=24) with a simple responding bus model.
module tb_jt900h_udma_eng;

    localparam int AW = 24;

    logic          rst, clk, cen;
    logic [31:0]   regin;
    logic [5:0]    regsel;
    logic [2:0]    regwe;
    logic          int_inc, int_dec;
    logic [31:0]   regout;
    logic [3:0]    trig, tc_irq;
    logic          busy, bus_req, bus_we, bus_ack;
    logic [1:0]    bus_size;
    logic [AW-1:0] bus_addr;
    logic [31:0]   bus_dout, bus_din;

    int passed = 0;
    int total  = 0;
    int fails  = 0;
    int tc_cnt [4];

    jt900h_udma_eng #(.NCH(4), .AW(AW)) dut (
        .rst(rst), .clk(clk), .cen(cen),
        .regin(regin), .regsel(regsel), .regwe(regwe),
        .int_inc(int_inc), .int_dec(int_dec), .regout(regout),
        .trig(trig), .tc_irq(tc_irq), .busy(busy),
        .bus_req(bus_req), .bus_we(bus_we), .bus_size(bus_size),
        .bus_addr(bus_addr), .bus_dout(bus_dout), .bus_din(bus_din), .bus_ack(bus_ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial for (int i = 0; i < 4; i++) tc_cnt[i] = 0;
    always @(negedge clk) for (int i = 0; i < 4; i++) if (tc_irq[i]) tc_cnt[i]++;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wreg(input logic [1:0] bank, input logic [1:0] ch, input logic [1:0] ln,
                        input logic [2:0] we, input logic [31:0] d);
        regsel = {bank, ch, ln};
        regin  = d;
        regwe  = we;
        tick();
        regwe  = 3'b000;
    endtask

    task automatic rchk(input string tag, input logic [1:0] bank, input logic [1:0] ch,
                        input logic [31:0] exp);
        regsel = {bank, ch, 2'b00};
        tick();
        check(tag, regout, exp);
    endtask

    task automatic pulse(input logic [3:0] t);
        trig = t;
        tick();
        trig = 4'b0000;
    endtask

    // Wait for a bus request, optionally hold off ack, then complete it with din.
    task automatic serve(input int delay, input logic [31:0] din,
                         output logic [AW-1:0] a, output logic we, output logic [31:0] dout,
                         output logic [1:0] sz, output logic steady);
        int n;
        n = 0;
        steady = 1'b1;
        while (!bus_req && n < 50) begin
            tick();
            n++;
        end
        if (!bus_req) begin
            a = 'x; we = 'x; dout = 'x; sz = 'x; steady = 1'b0;
            return;
        end
        a = bus_addr; we = bus_we; dout = bus_dout; sz = bus_size;
        for (int k = 0; k < delay; k++) begin
            tick();
            if (!bus_req || bus_addr !== a || bus_we !== we) steady = 1'b0;
        end
        bus_din = din;
        bus_ack = 1'b1;
        tick();
        bus_ack = 1'b0;
        bus_din = 32'd0;
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        while (busy && n < 40) begin
            tick();
            n++;
        end
        check(tag, {31'd0, busy}, 32'd0);
        tick();
    endtask

    initial begin
        logic [AW-1:0] a, a2;
        logic          we, st;
        logic [31:0]   d;
        logic [1:0]    sz;

        rst = 1'b1; cen = 1'b1; regin = 32'd0; regsel = 6'd0; regwe = 3'b000;
        int_inc = 1'b0; int_dec = 1'b0; trig = 4'b0000; bus_din = 32'd0; bus_ack = 1'b0;
        repeat (3) tick();
        rst = 1'b0;
        tick();

        // Reset state
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_bus_req", {31'd0, bus_req}, 32'd0);
        check("rst_tc_irq", {28'd0, tc_irq}, 32'd0);
        check("rst_bus_addr", {8'd0, bus_addr}, 32'd0);
        for (int b = 0; b < 4; b++)
            for (int c = 0; c < 4; c++)
                rchk($sformatf("rst_reg_b%0d_c%0d", b, c), 2'(b), 2'(c), 32'd0);

        // ch0: byte mode, src+=1, cnt=2
        wreg(2'd0, 2'd0, 2'd0, 3'b100, 32'h100);
        wreg(2'd1, 2'd0, 2'd0, 3'b100, 32'h200);
        wreg(2'd2, 2'd0, 2'd0, 3'b100, 32'h0002_0002);
        rchk("t2_cfg", 2'd2, 2'd0, 32'h0002_0002);
        pulse(4'b0001);
        serve(0, 32'h5A, a, we, d, sz, st);
        check("t2a_rd_addr", {8'd0, a}, 32'h100);
        check("t2a_rd_we", {31'd0, we}, 32'd0);
        check("t2a_rd_size", {30'd0, sz}, 32'd0);
        serve(0, 32'h0, a, we, d, sz, st);
        check("t2a_wr_addr", {8'd0, a}, 32'h200);
        check("t2a_wr_we", {31'd0, we}, 32'd1);
        check("t2a_wr_dout", d, 32'h5A);
        wait_idle("t2a_idle");
        rchk("t2a_src", 2'd0, 2'd0, 32'h101);
        rchk("t2a_cnt", 2'd2, 2'd0, 32'h0002_0001);
        check("t2a_tc", tc_cnt[0], 32'd0);
        pulse(4'b0001);
        serve(0, 32'hC3, a, we, d, sz, st);
        check("t2b_rd_addr", {8'd0, a}, 32'h101);
        serve(0, 32'h0, a, we, d, sz, st);
        check("t2b_wr_addr", {8'd0, a}, 32'h200);
        check("t2b_wr_dout", d, 32'hC3);
        wait_idle("t2b_idle");
        rchk("t2b_src", 2'd0, 2'd0, 32'h102);
        rchk("t2b_cnt", 2'd2, 2'd0, 32'h0002_0000);
        check("t2b_tc", tc_cnt[0], 32'd1);

        // ch1/ch2: op none, cnt=5, configured through word/byte lanes
        wreg(2'd0, 2'd1, 2'd0, 3'b100, 32'h300);
        wreg(2'd1, 2'd1, 2'd0, 3'b100, 32'h310);
        wreg(2'd2, 2'd1, 2'd2, 3'b001, 32'h04);
        wreg(2'd2, 2'd1, 2'd0, 3'b010, 32'h5);
        wreg(2'd0, 2'd2, 2'd0, 3'b010, 32'h0400);
        wreg(2'd1, 2'd2, 2'd1, 3'b001, 32'h04);
        wreg(2'd1, 2'd2, 2'd0, 3'b001, 32'h10);
        wreg(2'd2, 2'd2, 2'd0, 3'b100, 32'h0004_0005);
        rchk("t3_src2_word", 2'd0, 2'd2, 32'h400);
        rchk("t3_dst2_bytes", 2'd1, 2'd2, 32'h410);
        rchk("t3_cfg1", 2'd2, 2'd1, 32'h0004_0005);
        pulse(4'b0010);
        serve(0, 32'h11, a, we, d, sz, st);
        check("t3_solo_rd", {8'd0, a}, 32'h300);
        serve(0, 32'h0, a, we, d, sz, st);
        check("t3_solo_wr", {8'd0, a}, 32'h310);
        wait_idle("t3_solo_idle");
        pulse(4'b0110);
        serve(0, 32'h22, a, we, d, sz, st);
        serve(0, 32'h0, a2, we, d, sz, st);
        serve(0, 32'h33, a2, we, d, sz, st);
        check("t3_pair_order", {8'd0, a, a2[7:0]},
`ifdef JT900H_UDMA_ROTPRIO_EN
              {8'd0, 24'h400, 8'h00}
`else
              {8'd0, 24'h300, 8'h00}
`endif
        );
        serve(0, 32'h0, a2, we, d, sz, st);
        wait_idle("t3_pair_idle");
        rchk("t3_src1_kept", 2'd0, 2'd1, 32'h300);
        rchk("t3_cnt1", 2'd2, 2'd1, 32'h0004_0003);
        rchk("t3_cnt2", 2'd2, 2'd2, 32'h0004_0004);
        check("t3_tc1", tc_cnt[1], 32'd0);

        // ch3: long, dst-=4, ack held off on the write cycle
        wreg(2'd0, 2'd3, 2'd0, 3'b100, 32'h2000);
        wreg(2'd1, 2'd3, 2'd0, 3'b100, 32'h1000);
        wreg(2'd2, 2'd3, 2'd0, 3'b100, 32'h0011_0001);
        pulse(4'b1000);
        serve(0, 32'hDEAD_BEEF, a, we, d, sz, st);
        check("t4_rd_addr", {8'd0, a}, 32'h2000);
        check("t4_rd_size", {30'd0, sz}, 32'd2);
        serve(5, 32'h0, a, we, d, sz, st);
        check("t4_wr_addr", {8'd0, a}, 32'h1000);
        check("t4_wr_dout", d, 32'hDEAD_BEEF);
        check("t4_wr_stable", {31'd0, st}, 32'd1);
        wait_idle("t4_idle");
        rchk("t4_dst", 2'd1, 2'd3, 32'hFFC);
        check("t4_tc", tc_cnt[3], 32'd1);
        pulse(4'b1000);
        serve(0, 32'h1, a, we, d, sz, st);
        serve(0, 32'h0, a, we, d, sz, st);
        check("t4b_wr_addr", {8'd0, a}, 32'hFFC);
        wait_idle("t4b_idle");
        rchk("t4b_dst", 2'd1, 2'd3, 32'hFF8);
        rchk("t4b_cnt_wrap", 2'd2, 2'd3, 32'h0011_FFFF);
        check("t4b_tc", tc_cnt[3], 32'd1);

        // intnest
        rchk("t5_in0", 2'd3, 2'd0, 32'd0);
        int_dec = 1'b1; tick(); int_dec = 1'b0;
        rchk("t5_dec_sat", 2'd3, 2'd0, 32'd0);
        int_inc = 1'b1; repeat (3) tick(); int_inc = 1'b0;
        rchk("t5_inc3", 2'd3, 2'd0, 32'd3);
        int_inc = 1'b1; int_dec = 1'b1; tick(); int_inc = 1'b0; int_dec = 1'b0;
        rchk("t5_incdec", 2'd3, 2'd0, 32'd3);
        wreg(2'd3, 2'd0, 2'd0, 3'b010, 32'hFFFF);
        int_inc = 1'b1; tick(); int_inc = 1'b0;
        rchk("t5_inc_sat", 2'd3, 2'd0, 32'h0000_FFFF);

        // Reset while a write cycle is outstanding, with ch2 also pending
        pulse(4'b0101);
        serve(0, 32'h77, a, we, d, sz, st);
        check("t6_in_wr_req", {31'd0, bus_req}, 32'd1);
        check("t6_in_wr_we", {31'd0, bus_we}, 32'd1);
        rst = 1'b1;
        #1;
        check("t6_rst_req", {31'd0, bus_req}, 32'd0);
        check("t6_rst_busy", {31'd0, busy}, 32'd0);
        tick();
        rst = 1'b0;
        tick();
        rchk("t6_src0", 2'd0, 2'd0, 32'd0);
        rchk("t6_dst3", 2'd1, 2'd3, 32'd0);
        rchk("t6_cnt2", 2'd2, 2'd2, 32'd0);
        rchk("t6_intnest", 2'd3, 2'd0, 32'd0);
        repeat (8) tick();
        check("t6_no_pending_busy", {31'd0, busy}, 32'd0);
        check("t6_no_pending_req", {31'd0, bus_req}, 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
